// File: rtl/sign_narrow_unit_pkg.sv
// Shared definitions for the 32->16 signed narrowing path.
// Holds the word/halfword widths, the saturation limits and the narrowing
// function (fit test plus wrap or saturate), so the decoder side can reuse
// exactly the same rule as the store path.
package sign_narrow_unit_pkg;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;

  localparam logic [OUT_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [OUT_W-1:0] SAT_NEG = 16'h8000;

  // Buffered result: overflow flag above the narrowed halfword.
  typedef struct packed {
    logic             ovf;
    logic [OUT_W-1:0] data;
  } narrow_t;

  // A word fits when every bit from the top down to the halfword sign bit
  // agrees, i.e. sign-extending the low half reproduces the whole word.
  function automatic narrow_t narrow(input logic [IN_W-1:0] word,
                                     input logic            sat);
    narrow_t r;
    logic    fits;
    fits   = (word[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){word[IN_W-1]}});
    r.ovf  = !fits;
    r.data = word[OUT_W-1:0];
    if (!fits && sat) begin
      r.data = word[IN_W-1] ? SAT_NEG : SAT_POS;
    end
    return r;
  endfunction

endpackage

// File: rtl/sign_narrow_unit_fifo2.sv
// Two-entry in-order FIFO for {ovf, data} results.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write strobe (only when in_ready) and entry
//   pop             read strobe (only when out_valid)
//   dout            head entry, registered; holds its last value when empty
//   out_valid       head valid, registered
//   in_ready        room available, registered from next occupancy so that
//                   pop never reaches in_ready combinationally
// Storage is a head/tail shift pair rather than a pointer-addressed array,
// so the head is a plain register with no read mux in front of it.
module sign_narrow_unit_fifo2
  import sign_narrow_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [OUT_W:0] din,
  input  logic           pop,
  output logic [OUT_W:0] dout,
  output logic           out_valid,
  output logic           in_ready
);

  logic [1:0]     count;
  logic [1:0]     count_nxt;
  logic [OUT_W:0] head;
  logic [OUT_W:0] tail;

  // NOTE: default assignment first so every path drives count_nxt and no
  // latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // pre-edge values. Both storage slots are reset as well: there are only
  // two, and a defined out_data after reset is part of the contract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 2'd0;
      head      <= '0;
      tail      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      count     <= count_nxt;
      out_valid <= (count_nxt != 2'd0);
      in_ready  <= (count_nxt < 2'd2);
      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          head <= din;
        end else if (count == 2'd2) begin
          // Full with a push implies a simultaneous pop: shift and refill.
          head <= tail;
          tail <= din;
        end else begin
          tail <= din;
        end
      end else if (pop && count == 2'd2) begin
        head <= tail;
      end
    end
  end

  assign dout = head;

endmodule

// File: rtl/sign_narrow_unit.sv
// Narrows 32-bit signed datapath words to 16-bit signed halfwords.
// Overflowing words are wrapped or saturated (chosen per word by sat_en),
// results are buffered in a 2-entry FIFO with valid/ready on both sides,
// and accepted overflowing words are counted.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready registered)
//   in_data, sat_en      word to narrow, saturate(1)/wrap(0) select
//   out_valid/out_ready  output handshake
//   out_data, out_ovf    narrowed halfword and its overflow flag
//   ovf_clr, ovf_count   synchronous clear, saturating overflow count
module sign_narrow_unit
  import sign_narrow_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic [15:0]      ovf_count
);

  narrow_t        res;
  narrow_t        head;
  logic           accept;
  logic           pop;
  logic           ovf_hit;

  assign res     = narrow(in_data, sat_en);
  assign accept  = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  assign ovf_hit = accept && res.ovf;

  sign_narrow_unit_fifo2 u_fifo2 (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .din       (res),
    .pop       (pop),
    .dout      (head),
    .out_valid (out_valid),
    .in_ready  (in_ready)
  );

  assign out_data = head.data;
  assign out_ovf  = head.ovf;

  // Clear wins over the old value but still counts an overflow accepted in
  // the same cycle, so the result is 1 rather than 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= 16'd0;
    end else if (ovf_clr) begin
      ovf_count <= ovf_hit ? 16'd1 : 16'd0;
    end else if (ovf_hit && ovf_count != 16'hFFFF) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sign_narrow_unit.sv
// Scoreboard bench for sign_narrow_unit: the stimulus side pushes expected
// {ovf, data} results computed by an arithmetic reference model, and a
// monitor pops and compares on every output handshake.
module tb_sign_narrow_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        ovf_clr;
  logic [15:0] ovf_count;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  int          exp_cnt = 0;

  always #5 clk = ~clk;

  sign_narrow_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_clr   (ovf_clr),
    .ovf_count (ovf_count)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word fits when its signed value lies in the halfword range.
  function automatic logic [16:0] model(input logic [31:0] w, input logic s);
    longint v;
    v = longint'($signed(w));
    if (v >= -32768 && v <= 32767) return {1'b0, w[15:0]};
    if (!s)                        return {1'b1, w[15:0]};
    if (v < 0)                     return {1'b1, 16'h8000};
    return {1'b1, 16'h7FFF};
  endfunction

  // One clock of stimulus. Inputs change 1 time unit after the rising edge;
  // the accept decision is read at the falling edge.
  task automatic step(input logic v, input logic [31:0] w, input logic s,
                      input logic c, input logic r, output logic acc);
    logic [16:0] e;
    int          nxt;
    in_valid  = v;
    in_data   = w;
    sat_en    = s;
    ovf_clr   = c;
    out_ready = r;
    @(negedge clk);
    acc = v && in_ready;
    e   = model(w, s);
    if (acc) exp_q.push_back(e);
    nxt = exp_cnt;
    if (c)                               nxt = (acc && e[16]) ? 1 : 0;
    else if (acc && e[16] && nxt < 65535) nxt = nxt + 1;
    @(posedge clk);
    #1;
    exp_cnt   = nxt;
    in_valid  = 1'b0;
    ovf_clr   = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic s, input logic r);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      step(1'b1, w, s, 1'b0, r, acc);
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    check("drain_done", {31'd0, out_valid}, 32'd0);
  endtask

  // Monitor: every handshake at the falling edge commits at the next rise.
  initial begin
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", {15'd0, out_ovf, out_data}, 32'h1FFFF);
          end else begin
            e = exp_q.pop_front();
            check("out_word", {15'd0, out_ovf, out_data}, {15'd0, e});
          end
        end
        check("ovf_count", {16'd0, ovf_count}, exp_cnt);
      end
    end
  end

  logic [31:0] corners [8];

  initial begin
    logic acc;
    logic all_acc;
    logic [31:0] w;
    corners[0] = 32'h00007FFF; corners[1] = 32'hFFFF8000;
    corners[2] = 32'h00008000; corners[3] = 32'hFFFF7FFF;
    corners[4] = 32'h80000000; corners[5] = 32'h7FFFFFFF;
    corners[6] = 32'h00000000; corners[7] = 32'hFFFFFFFF;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; sat_en = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_data",  {16'd0, out_data},  32'd0);
    check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
    check("rst_ovf_count", {16'd0, ovf_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fit, negative; one-cycle latency into an empty buffer.
    step(1'b1, 32'hFFFFEFFF, 1'b1, 1'b0, 1'b1, acc);
    check("fit_accept", {31'd0, acc}, 32'd1);
    check("fit_latency_valid", {31'd0, out_valid}, 32'd1);
    check("fit_data", {16'd0, out_data}, 32'h0000EFFF);
    drain();

    // Overflow: saturate then wrap.
    send(32'h0000A40A, 1'b1, 1'b1);
    drain();
    check("sat_pos_cnt", {16'd0, ovf_count}, 32'd1);
    send(32'h0000A40A, 1'b0, 1'b1);
    drain();
    check("wrap_cnt", {16'd0, ovf_count}, 32'd2);
    send(32'h80000000, 1'b1, 1'b1);
    send(32'h00007FFF, 1'b1, 1'b1);
    send(32'hFFFF8000, 1'b1, 1'b1);
    drain();

    // Backpressure: three back-to-back offers with out_ready low.
    step(1'b1, 32'h00001111, 1'b0, 1'b0, 1'b0, acc);
    check("bp_acc0", {31'd0, acc}, 32'd1);
    step(1'b1, 32'h00012222, 1'b1, 1'b0, 1'b0, acc);
    check("bp_acc1", {31'd0, acc}, 32'd1);
    step(1'b1, 32'hFFFF3333, 1'b0, 1'b0, 1'b0, acc);
    check("bp_acc2_blocked", {31'd0, acc}, 32'd0);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    send(32'hFFFF3333, 1'b0, 1'b1);
    drain();

    // Simultaneous push and pop at count=1.
    send(32'h00000AAA, 1'b0, 1'b0);
    step(1'b1, 32'hFFFFFBBB, 1'b0, 1'b0, 1'b1, acc);
    check("pp_acc", {31'd0, acc}, 32'd1);
    check("pp_valid", {31'd0, out_valid}, 32'd1);
    check("pp_in_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // Randomized traffic with boundary-biased words.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       w = corners[$urandom_range(0, 7)];
        1:       w = $urandom_range(0, 65535) - 32'd32768 + {$urandom_range(0, 2) - 1};
        default: w = $urandom;
      endcase
      step(($urandom_range(0, 3) != 0), w, $urandom_range(0, 1),
           ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), acc);
    end
    drain();

    // Counter saturation and clear.
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, acc);
    all_acc = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      step(1'b1, 32'h00010000, i[0], 1'b0, 1'b1, acc);
      all_acc = all_acc & acc;
    end
    check("full_throughput", {31'd0, all_acc}, 32'd1);
    drain();
    check("cnt_at_max", {16'd0, ovf_count}, 32'h0000FFFF);
    send(32'hF0000000, 1'b1, 1'b1);
    drain();
    check("cnt_saturated", {16'd0, ovf_count}, 32'h0000FFFF);
    step(1'b1, 32'h12345678, 1'b0, 1'b1, 1'b1, acc);
    drain();
    check("clr_with_ovf", {16'd0, ovf_count}, 32'd1);

    // Async reset with a full buffer.
    send(32'h00000001, 1'b0, 1'b0);
    send(32'h00000002, 1'b0, 1'b0);
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready",  {31'd0, in_ready},  32'd1);
    check("arst_ovf_count", {16'd0, ovf_count}, 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'hFFFFFFFE, 1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
